// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and helpers for the iterative divider
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Iteration counter must hold values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift {rem, quo} left, trial-subtract divisor, restore on borrow.
  // rem < div keeps every value inside WIDTH+1 bits, so trial[WIDTH] is the sign.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, div_i};
    if (trial[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - multi-cycle signed/unsigned restoring divider
module divider_iter
  import divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] R,
  output logic             ok,
  output logic             err,
  output logic             busy
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] res_d_q, res_d_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;
  logic [WIDTH-1:0] rem_s, quo_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (rem_s),
    .quo_o (quo_s)
  );

  // Operand magnitudes; sign logic collapses to constants when SIGNED_EN=0.
  // A start coinciding with the ok pulse is dropped as well.
  always_comb begin
    signed_op = SIGNED_EN && is_signed;
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    a_mag     = a_neg ? (-A) : A;
    b_mag     = b_neg ? (-B) : B;
    accept    = (state_q == ST_IDLE) && start && !ok_q;
  end

  // Next-state: capture in IDLE, one step per cycle in CALC, sign fix in FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d_d = res_d_q;
    res_r_d = res_r_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (B == '0) begin
            res_d_d = '1;
            res_r_d = A;
            err_d   = 1'b1;
          end else begin
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            quo_d   = a_mag;
            div_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = rem_s;
        quo_d = quo_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        // MIN / -1 wraps naturally to MIN with zero remainder.
        res_d_d = negq_q ? (-quo_q) : quo_q;
        res_r_d = negr_q ? (-rem_q) : rem_q;
        ok_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_d_q <= '0;
      res_r_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_d_q <= res_d_d;
      res_r_q <= res_r_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign D    = res_d_q;
  assign R    = res_r_q;
  assign ok   = ok_q;
  assign err  = err_q;
  assign busy = (state_q != ST_IDLE);

endmodule
